// File: rtl/adc_sample_buffer_if.sv
// Word stream and burst-control signals between adc_sample_buffer and the M00_AXI burst-write master.
interface adc_sample_buffer_if;
    logic        WORD_TVALID;
    logic [31:0] WORD_TDATA;
    logic        WORD_TREADY;
    logic        INIT_AXI_TXN;
    logic        TXN_DONE;

    modport master (
        output WORD_TVALID, WORD_TDATA, INIT_AXI_TXN,
        input  WORD_TREADY, TXN_DONE
    );

    modport slave (
        input  WORD_TVALID, WORD_TDATA, INIT_AXI_TXN,
        output WORD_TREADY, TXN_DONE
    );
endinterface

// File: rtl/adc_sample_buffer.sv
// ADC capture, 32-bit word packing, FWFT FIFO and burst sequencer feeding the M00_AXI master.
// Define ADC_SAMPLE_PACK_EN to pack two samples per word; otherwise one zero-extended sample per word.
module adc_sample_buffer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int BURST_WORDS  = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        ENABLE,
    input  logic                        ADC_SAMPLE_VALID,
    input  logic [SAMPLE_WIDTH-1:0]     ADC_SAMPLE_DATA,
    input  logic                        CLEAR,
    output logic                        OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    adc_sample_buffer_if.master         word_if
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BURST_WORDS + 1);

    typedef enum logic [1:0] {IDLE, START, DRAIN, WAIT_DONE} state_t;

    state_t        state;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] burst_cnt;
    logic [15:0]   sample_half;
    logic          sample_take;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic [31:0]   push_word;

    always_comb begin
        sample_half = 16'(ADC_SAMPLE_DATA);
        sample_take = ENABLE && ADC_SAMPLE_VALID && !CLEAR;
    end

`ifdef ADC_SAMPLE_PACK_EN
    logic        half_sel;
    logic [15:0] low_half;

    // half_sel toggles on every accepted sample, so a dropped word still returns it to 0
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            half_sel <= 1'b0;
            low_half <= '0;
        end else if (CLEAR) begin
            half_sel <= 1'b0;
        end else if (sample_take) begin
            half_sel <= ~half_sel;
            if (!half_sel) low_half <= sample_half;
        end
    end

    always_comb begin
        push_req  = sample_take && half_sel;
        push_word = {sample_half, low_half};
    end
`else
    always_comb begin
        push_req  = sample_take;
        push_word = {16'h0000, sample_half};
    end
`endif

    always_comb begin
        pop     = (state == DRAIN) && word_if.WORD_TVALID && word_if.WORD_TREADY;
        push_ok = push_req && ((FIFO_LEVEL < LW'(FIFO_DEPTH)) || pop);
    end

    always_ff @(posedge ACLK) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
                2'b01:   FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
                default: ;
            endcase
            if (CLEAR)                      OVERFLOW <= 1'b0;
            else if (push_req && !push_ok)  OVERFLOW <= 1'b1;
        end
    end

    // First-word-fall-through head; forced to zero while empty so reset shows a clean bus
    always_comb begin
        word_if.WORD_TDATA = (FIFO_LEVEL != '0) ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state                <= IDLE;
            word_if.INIT_AXI_TXN <= 1'b0;
            word_if.WORD_TVALID  <= 1'b0;
            burst_cnt            <= '0;
        end else begin
            word_if.INIT_AXI_TXN <= 1'b0;
            case (state)
                IDLE: begin
                    if (FIFO_LEVEL >= LW'(BURST_WORDS)) begin
                        state                <= START;
                        word_if.INIT_AXI_TXN <= 1'b1;
                    end
                end
                START: begin
                    state     <= DRAIN;
                    burst_cnt <= '0;
                end
                DRAIN: begin
                    if (pop) begin
                        if (burst_cnt == CW'(BURST_WORDS - 1)) begin
                            word_if.WORD_TVALID <= 1'b0;
                            burst_cnt           <= '0;
                            state               <= WAIT_DONE;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (!word_if.WORD_TVALID) begin
                        word_if.WORD_TVALID <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (word_if.TXN_DONE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed bench for adc_sample_buffer; builds with or without ADC_SAMPLE_PACK_EN.
module tb_adc_sample_buffer;
    localparam int SAMPLE_WIDTH = 16;
    localparam int FIFO_DEPTH   = 16;
    localparam int BURST_WORDS  = 8;
`ifdef ADC_SAMPLE_PACK_EN
    localparam int          SPW        = 2;
    localparam logic [31:0] FIRST_WORD = 32'h0002_0001;
    localparam logic [31:0] LAST_WORD  = 32'h0010_000F;
    localparam logic [31:0] SIMUL_WORD = 32'h0A04_0A03;
    localparam logic [31:0] FRESH_WORD = 32'h2001_2000;
`else
    localparam int          SPW        = 1;
    localparam logic [31:0] FIRST_WORD = 32'h0000_0001;
    localparam logic [31:0] LAST_WORD  = 32'h0000_0008;
    localparam logic [31:0] SIMUL_WORD = 32'h0000_0A04;
    localparam logic [31:0] FRESH_WORD = 32'h0000_2000;
`endif

    logic                    ACLK;
    logic                    ARESET;
    logic                    ENABLE;
    logic                    ADC_SAMPLE_VALID;
    logic [SAMPLE_WIDTH-1:0] ADC_SAMPLE_DATA;
    logic                    CLEAR;
    logic                    OVERFLOW;
    logic [4:0]              FIFO_LEVEL;

    adc_sample_buffer_if word_if ();

    adc_sample_buffer #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .BURST_WORDS  (BURST_WORDS)
    ) dut (
        .ACLK             (ACLK),
        .ARESET           (ARESET),
        .ENABLE           (ENABLE),
        .ADC_SAMPLE_VALID (ADC_SAMPLE_VALID),
        .ADC_SAMPLE_DATA  (ADC_SAMPLE_DATA),
        .CLEAR            (CLEAR),
        .OVERFLOW         (OVERFLOW),
        .FIFO_LEVEL       (FIFO_LEVEL),
        .word_if          (word_if)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected FIFO contents, updated half a cycle ahead of each edge
    logic [31:0] exp_q[$];
    logic [15:0] m_lo;
    bit          m_half;
    int          init_cnt   = 0;
    int          burst_pops = 0;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [31:0] last_pop;
    logic [31:0] exp_word;

    task automatic model_push(input logic [31:0] w);
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(w);
    endtask

    always @(negedge ACLK) begin
        if (ARESET) begin
            exp_q.delete();
            m_half     = 1'b0;
            burst_pops = 0;
            prev_stall = 1'b0;
        end else begin
            if (word_if.INIT_AXI_TXN) begin
                init_cnt++;
                burst_pops = 0;
            end
            if (prev_stall) begin
                check("hold_tvalid", word_if.WORD_TVALID, 1);
                check("hold_tdata", word_if.WORD_TDATA, prev_data);
            end
            if (word_if.WORD_TVALID && word_if.WORD_TREADY) begin
                exp_word = 32'hDEAD_BEEF;
                if (exp_q.size() > 0) exp_word = exp_q.pop_front();
                check("tdata", word_if.WORD_TDATA, exp_word);
                last_pop = word_if.WORD_TDATA;
                burst_pops++;
            end
            prev_stall = word_if.WORD_TVALID && !word_if.WORD_TREADY;
            prev_data  = word_if.WORD_TDATA;
            if (ENABLE && ADC_SAMPLE_VALID && !CLEAR) begin
`ifdef ADC_SAMPLE_PACK_EN
                if (!m_half) begin
                    m_lo   = ADC_SAMPLE_DATA;
                    m_half = 1'b1;
                end else begin
                    m_half = 1'b0;
                    model_push({ADC_SAMPLE_DATA, m_lo});
                end
`else
                model_push({16'h0000, ADC_SAMPLE_DATA});
`endif
            end else if (CLEAR) begin
                m_half = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic feed(input logic [15:0] s);
        ADC_SAMPLE_VALID = 1'b1;
        ADC_SAMPLE_DATA  = s;
        tick();
        ADC_SAMPLE_VALID = 1'b0;
    endtask

    task automatic pulse_done();
        word_if.TXN_DONE = 1'b1;
        tick();
        word_if.TXN_DONE = 1'b0;
        tick();
    endtask

    task automatic wait_init(input string tag, input int base);
        int k = 0;
        while (init_cnt == base && k < 100) begin
            tick();
            k++;
        end
        check(tag, init_cnt, base + 1);
    endtask

    task automatic wait_pops(input string tag, input int n);
        int k = 0;
        while (burst_pops < n && k < 200) begin
            tick();
            k++;
        end
        check(tag, burst_pops, n);
    endtask

    task automatic wait_tvalid(input string tag);
        int k = 0;
        while (!word_if.WORD_TVALID && k < 20) begin
            tick();
            k++;
        end
        check(tag, word_if.WORD_TVALID, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"}, word_if.WORD_TVALID, 0);
        check({tag, "_tdata"}, word_if.WORD_TDATA, 0);
        check({tag, "_init"}, word_if.INIT_AXI_TXN, 0);
        check({tag, "_ovf"}, OVERFLOW, 0);
        check({tag, "_level"}, FIFO_LEVEL, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int base;

    initial begin
        ARESET = 1'b1; ENABLE = 1'b0; ADC_SAMPLE_VALID = 1'b0; ADC_SAMPLE_DATA = '0;
        CLEAR = 1'b0; word_if.WORD_TREADY = 1'b0; word_if.TXN_DONE = 1'b0;
        tick(); tick();
        check_all_zero("rst");
        ARESET = 1'b0;
        tick();

        // Basic burst and latency
        ENABLE = 1'b1;
        word_if.WORD_TREADY = 1'b1;
        for (int i = 0; i < 8 * SPW; i++) feed(16'(i + 1));
        check("level_burst", FIFO_LEVEL, 8);
        tick();
        check("init_pulse", word_if.INIT_AXI_TXN, 1);
        tick();
        check("init_one_cycle", word_if.INIT_AXI_TXN, 0);
        check("tvalid_early", word_if.WORD_TVALID, 0);
        tick();
        check("tvalid_latency", word_if.WORD_TVALID, 1);
        check("first_word", word_if.WORD_TDATA, FIRST_WORD);
        wait_pops("burst1_pops", 8);
        check("last_word", last_pop, LAST_WORD);
        repeat (3) begin
            check("no_ninth", word_if.WORD_TVALID, 0);
            tick();
        end
        pulse_done();
        check("level_empty", FIFO_LEVEL, 0);
        check("init_once", init_cnt, 1);

        // Backpressure
        base = init_cnt;
        for (int i = 0; i < 8 * SPW; i++) feed(16'(16'h0100 + i));
        wait_init("bp_init", base);
        for (int k = 0; k < 100 && burst_pops < 8; k++) begin
            word_if.WORD_TREADY = ~word_if.WORD_TREADY;
            tick();
        end
        check("bp_pops", burst_pops, 8);
        word_if.WORD_TREADY = 1'b1;
        repeat (3) begin
            check("bp_no_ninth", word_if.WORD_TVALID, 0);
            tick();
        end
        pulse_done();
        check("bp_level", FIFO_LEVEL, 0);

        // Overflow
        word_if.WORD_TREADY = 1'b0;
        base = init_cnt;
        for (int i = 0; i < 16 * SPW; i++) feed(16'(16'h0300 + i));
        check("ovf_at_full", OVERFLOW, 0);
        check("level_at_full", FIFO_LEVEL, 16);
        for (int i = 16 * SPW; i < 17 * SPW; i++) feed(16'(16'h0300 + i));
        check("ovf_17th", OVERFLOW, 1);
        check("level_17th", FIFO_LEVEL, 16);
        for (int i = 17 * SPW; i < 40; i++) feed(16'(16'h0300 + i));
        check("ovf_sticky", OVERFLOW, 1);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        check("ovf_clear", OVERFLOW, 0);
        check("level_after_clear", FIFO_LEVEL, 16);
        check("ovf_burst_started", init_cnt, base + 1);
        check("ovf_tvalid_held", word_if.WORD_TVALID, 1);

        // CLEAR discards a same-cycle sample; then push and pop together on a full FIFO
`ifdef ADC_SAMPLE_PACK_EN
        feed(16'h0A01);
`endif
        CLEAR = 1'b1;
        feed(16'h0A02);
        CLEAR = 1'b0;
        check("clear_sample_ovf", OVERFLOW, 0);
        check("clear_sample_level", FIFO_LEVEL, 16);
`ifdef ADC_SAMPLE_PACK_EN
        feed(16'h0A03);
`endif
        word_if.WORD_TREADY = 1'b1;
        feed(16'h0A04);
        word_if.WORD_TREADY = 1'b0;
        check("simul_level", FIFO_LEVEL, 16);
        check("simul_ovf", OVERFLOW, 0);
        check("simul_pops", burst_pops, 1);
        word_if.WORD_TREADY = 1'b1;
        wait_pops("simul_burst_pops", 8);
        base = init_cnt;
        pulse_done();
        wait_init("burst2_init", base);
        wait_pops("burst2_pops", 8);
        pulse_done();
        check("level_residual", FIFO_LEVEL, 1);

        // Reset in the middle of a burst
        base = init_cnt;
        for (int i = 0; i < 7 * SPW; i++) feed(16'(16'h0B00 + i));
        wait_init("burst3_init", base);
        wait_tvalid("burst3_tvalid");
        check("burst3_first_word", word_if.WORD_TDATA, SIMUL_WORD);
        wait_pops("burst3_pops", 3);
        #2;
        ARESET = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick(); tick();
        ARESET = 1'b0;
        tick();

        ENABLE = 1'b0;
        feed(16'h1111);
        feed(16'h2222);
        check("enable_low_level", FIFO_LEVEL, 0);
        ENABLE = 1'b1;
        base = init_cnt;
        for (int i = 0; i < 8 * SPW; i++) feed(16'(16'h2000 + i));
        wait_init("fresh_init", base);
        wait_tvalid("fresh_tvalid");
        check("fresh_first_word", word_if.WORD_TDATA, FRESH_WORD);
        wait_pops("fresh_pops", 8);
        tick();
        check("fresh_no_ninth", word_if.WORD_TVALID, 0);
        pulse_done();
        check("fresh_level", FIFO_LEVEL, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
